// File: rtl/tff_toggle_decoder_pkg.sv
// Shared definitions for the toggle-line event decoder: default sizes and FSM states.
package tff_toggle_decoder_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned EVT_W_DEF       = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/tff_toggle_decoder_sync.sv
// Synchroniser chain plus previous-level flop; flags every level change of tog_in.
module toggle_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tog_in,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Runs regardless of enable so that re-enabling never sees a stale level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tog_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign evt = sync[SYNC_STAGES-1] ^ prev;

endmodule

// File: rtl/tff_toggle_decoder.sv
// Toggle-line decoder: event pulse, event count and event-to-event period measurement.
module tff_toggle_decoder
  import tff_toggle_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned EVT_W       = EVT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             en,
  output logic             pulse_out,
  output logic [EVT_W-1:0] evt_cnt,
  output logic [CNT_W-1:0] per_data,
  output logic             per_ovf,
  output logic             per_valid,
  input  logic             per_ready,
  output logic             lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             evt;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] per_cnt, per_cnt_nxt;
  logic             sat, sat_nxt;
  logic             push_c;

  toggle_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .tog_in (tog_in),
    .evt    (evt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      per_cnt <= '0;
      sat     <= 1'b0;
    end else begin
      state   <= state_nxt;
      per_cnt <= per_cnt_nxt;
      sat     <= sat_nxt;
    end
  end

  // Period measurement: first event only arms, each later event closes a period.
  always_comb begin
    state_nxt   = state;
    per_cnt_nxt = per_cnt;
    sat_nxt     = sat;
    push_c      = 1'b0;
    if (!en) begin
      state_nxt   = ST_IDLE;
      per_cnt_nxt = '0;
      sat_nxt     = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (evt) begin
            state_nxt   = ST_MEASURE;
            per_cnt_nxt = CNT_W'(1);
            sat_nxt     = 1'b0;
          end
        end
        ST_MEASURE: begin
          if (evt) begin
            push_c      = 1'b1;
            per_cnt_nxt = CNT_W'(1);
            sat_nxt     = 1'b0;
          end else if (per_cnt == CNT_MAX) begin
            sat_nxt = 1'b1;
          end else begin
            per_cnt_nxt = per_cnt + CNT_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_out <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      pulse_out <= evt & en;
      if (evt && en) begin
        evt_cnt <= evt_cnt + EVT_W'(1);
      end
    end
  end

  // One-entry output register; a full, stalled register drops the new period.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_data  <= '0;
      per_ovf   <= 1'b0;
      per_valid <= 1'b0;
      lost      <= 1'b0;
    end else if (push_c) begin
      if (!per_valid || per_ready) begin
        per_data  <= per_cnt;
        per_ovf   <= sat;
        per_valid <= 1'b1;
      end else begin
        lost <= 1'b1;
      end
    end else if (per_valid && per_ready) begin
      per_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tff_toggle_decoder.sv
// Randomised/directed bench for tff_toggle_decoder with an event-time reference model and scoreboard.
module tb_tff_toggle_decoder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned EW   = 8;
  localparam int          MAX16 = 65535;
  localparam int          MAX4  = 15;

  logic clk = 1'b0;
  logic rst, tog_in, en, per_ready;

  logic          pulse_a, per_ovf_a, per_valid_a, lost_a;
  logic [EW-1:0] evt_cnt_a;
  logic [15:0]   per_data_a;
  logic          pulse_b, per_ovf_b, per_valid_b, lost_b;
  logic [EW-1:0] evt_cnt_b;
  logic [3:0]    per_data_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tff_toggle_decoder u_dut (
    .clk (clk), .rst (rst), .tog_in (tog_in), .en (en),
    .pulse_out (pulse_a), .evt_cnt (evt_cnt_a), .per_data (per_data_a),
    .per_ovf (per_ovf_a), .per_valid (per_valid_a), .per_ready (per_ready),
    .lost (lost_a)
  );

  tff_toggle_decoder #(.CNT_W (4)) u_dut4 (
    .clk (clk), .rst (rst), .tog_in (tog_in), .en (en),
    .pulse_out (pulse_b), .evt_cnt (evt_cnt_b), .per_data (per_data_b),
    .per_ovf (per_ovf_b), .per_valid (per_valid_b), .per_ready (per_ready),
    .lost (lost_b)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model state: sampled tog_in history, event times, buffer occupancy.
  bit hist[$];
  int cyc = 0, last_evt = 0, period = 0, m_cnt = 0;
  bit started = 0, just_rst = 0, measuring = 0, occ = 0, m_lost = 0, m_pulse = 0;
  bit ev, push;
  int q16[$], q4[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        hist.delete();
        repeat (SYNC + 1) hist.push_back(1'b0);
        measuring = 0; occ = 0; m_lost = 0; m_pulse = 0; m_cnt = 0;
        q16.delete(); q4.delete();
        started = 1; just_rst = 1;
      end else if (started) begin
        just_rst = 0;
        // A level first sampled at edge k is acted on at edge k+SYNC.
        ev = hist[SYNC-1] != hist[SYNC];
        hist.push_front(tog_in);
        void'(hist.pop_back());
        m_pulse = ev && en;
        if (m_pulse) m_cnt = (m_cnt + 1) % (1 << EW);
        push = 0;
        if (!en) measuring = 0;
        else if (ev) begin
          if (measuring) begin
            push = 1;
            period = cyc - last_evt;
          end
          measuring = 1;
          last_evt = cyc;
        end
        if (push) begin
          if (!occ || per_ready) begin
            occ = 1;
            q16.push_back(period);
            q4.push_back(period);
          end else m_lost = 1;
        end else if (occ && per_ready) occ = 0;
      end
    end
  end

  // Per-cycle output checks against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("pulse_out", int'(pulse_a), int'(m_pulse));
        check("evt_cnt", int'(evt_cnt_a), m_cnt);
        check("per_valid", int'(per_valid_a), int'(occ));
        check("lost", int'(lost_a), int'(m_lost));
        check("per_valid_w4", int'(per_valid_b), int'(occ));
        check("lost_w4", int'(lost_b), int'(m_lost));
        if (just_rst) begin
          check("rst_per_data", int'(per_data_a), 0);
          check("rst_per_ovf", int'(per_ovf_a), 0);
          check("rst_per_data_w4", int'(per_data_b), 0);
        end
      end
    end
  end

  // Scoreboard monitors: pop and compare whenever a result is handed over.
  int p16, p4;
  initial begin
    forever begin
      @(negedge clk);
      if (started && per_valid_a && per_ready) begin
        if (q16.size() == 0) check("unexpected_result", 1, 0);
        else begin
          p16 = q16.pop_front();
          check("per_data", int'(per_data_a), (p16 > MAX16) ? MAX16 : p16);
          check("per_ovf", int'(per_ovf_a), int'(p16 > MAX16));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started && per_valid_b && per_ready) begin
        if (q4.size() == 0) check("unexpected_result_w4", 1, 0);
        else begin
          p4 = q4.pop_front();
          check("per_data_w4", int'(per_data_b), (p4 > MAX4) ? MAX4 : p4);
          check("per_ovf_w4", int'(per_ovf_b), int'(p4 > MAX4));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flip();
    tog_in = ~tog_in;
  endtask

  initial begin
    rst = 1'b1; tog_in = 1'b0; en = 1'b1; per_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    // Slow toggling, period 8
    repeat (6) begin flip(); tick(8); end
    // Divide-by-4 source, period 2
    repeat (12) begin flip(); tick(2); end
    // Stall the consumer across two completed periods
    flip(); tick(2);
    per_ready = 1'b0;
    tick(6);
    flip(); tick(5);
    flip(); tick(6);
    per_ready = 1'b1;
    tick(4);
    // Long idle to saturate the narrow counter, then a short period
    tick(20);
    flip(); tick(3);
    flip(); tick(3);
    flip(); tick(6);
    // Suspend mid-measure while the line keeps toggling
    flip(); tick(3);
    en = 1'b0; tick(3);
    flip(); tick(3);
    flip(); tick(4);
    en = 1'b1; tick(2);
    flip(); tick(5);
    flip(); tick(7);
    flip(); tick(6);
    // Mid-stream reset, then wrap the event counter
    rst = 1'b1; tog_in = 1'b0;
    tick(1);
    rst = 1'b0;
    repeat (257) begin flip(); tick(2); end
    tick(6);
    check("evt_cnt_wrap", int'(evt_cnt_a), 1);
    // Random line activity, enable gaps and consumer stalls
    repeat (800) begin
      if ($urandom_range(0, 2) == 0) flip();
      en = ($urandom_range(0, 15) != 0);
      per_ready = ($urandom_range(0, 1) == 1);
      tick(1);
    end
    en = 1'b1; per_ready = 1'b1;
    tick(10);
    check("drain_q16", q16.size(), 0);
    check("drain_q4", q4.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
